// File: rtl/snax_csr_pkg.sv
// Shared types and address-map helpers for the SNAX CSR register bank.
// The map is laid out as: config RW, control, RO status, PERF.
package snax_csr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int unsigned CtrlStartBit = 0;

  function automatic int unsigned ctrl_addr(input int unsigned n_rw);
    return n_rw;
  endfunction

  function automatic int unsigned ro_base(input int unsigned n_rw);
    return n_rw + 1;
  endfunction

  function automatic int unsigned perf_addr(input int unsigned n_rw, input int unsigned n_ro);
    return n_rw + n_ro + 1;
  endfunction

endpackage

// File: rtl/snax_csr_regfile.sv
// CSR bank behind the SNAX interface translator: config registers, launch FSM,
// write interlock while running, busy-cycle counter and a one-entry read response.
module snax_csr_regfile
  import snax_csr_pkg::*;
#(
  parameter int unsigned NumRwCsr = 8,
  parameter int unsigned NumRoCsr = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [31:0]                csr_req_bits_data_i,
  input  logic [31:0]                csr_req_bits_addr_i,
  input  logic                       csr_req_bits_write_i,
  input  logic                       csr_req_valid_i,
  output logic                       csr_req_ready_o,
  output logic [31:0]                csr_rsp_bits_data_o,
  output logic                       csr_rsp_valid_o,
  input  logic                       csr_rsp_ready_i,
  output logic [NumRwCsr-1:0][31:0]  csr_o,
  input  logic [NumRoCsr-1:0][31:0]  csr_ro_i,
  output logic                       start_o,
  input  logic                       busy_i
);

  localparam logic [31:0] CtrlAddr = 32'(ctrl_addr(NumRwCsr));
  localparam logic [31:0] RoBase   = 32'(ro_base(NumRwCsr));
  localparam logic [31:0] PerfAddr = 32'(perf_addr(NumRwCsr, NumRoCsr));

  state_e                    state_r;
  logic [NumRwCsr-1:0][31:0] csr_r;
  logic [31:0]               perf_r;
  logic [31:0]               rsp_data_r;
  logic                      rsp_valid_r;
  logic                      start_r;
  logic [31:0]               rd_data_s;
  logic                      req_fire_s;
  logic                      wr_fire_s;
  logic                      rd_fire_s;
  logic                      launch_s;

  // Writes also wait for a free response slot so upstream ID ordering holds.
  assign csr_req_ready_o = (!rsp_valid_r || csr_rsp_ready_i) &&
                           (!csr_req_bits_write_i || (state_r == ST_IDLE));
  assign req_fire_s = csr_req_valid_i && csr_req_ready_o;
  assign wr_fire_s  = req_fire_s && csr_req_bits_write_i;
  assign rd_fire_s  = req_fire_s && !csr_req_bits_write_i;
  assign launch_s   = wr_fire_s && (state_r == ST_IDLE) &&
                      (csr_req_bits_addr_i == CtrlAddr) &&
                      csr_req_bits_data_i[CtrlStartBit];

  assign csr_o               = csr_r;
  assign csr_rsp_bits_data_o = rsp_data_r;
  assign csr_rsp_valid_o     = rsp_valid_r;
  assign start_o             = start_r;

  // Read mux over the address map; unmapped addresses read as zero.
  always_comb begin
    rd_data_s = 32'd0;
    for (int i = 0; i < int'(NumRwCsr); i++) begin
      if (csr_req_bits_addr_i == 32'(i)) rd_data_s = csr_r[i];
      else                               rd_data_s = rd_data_s;
    end
    for (int j = 0; j < int'(NumRoCsr); j++) begin
      if (csr_req_bits_addr_i == RoBase + 32'(j)) rd_data_s = csr_ro_i[j];
      else                                        rd_data_s = rd_data_s;
    end
    if (csr_req_bits_addr_i == CtrlAddr) begin
      rd_data_s = {30'd0, (state_r != ST_IDLE), 1'b0};
    end else if (csr_req_bits_addr_i == PerfAddr) begin
      rd_data_s = perf_r;
    end else begin
      rd_data_s = rd_data_s;
    end
  end

  // Configuration register bank.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csr_r <= '0;
    end else begin
      for (int i = 0; i < int'(NumRwCsr); i++) begin
        if (wr_fire_s && (csr_req_bits_addr_i == 32'(i))) csr_r[i] <= csr_req_bits_data_i;
      end
    end
  end

  // Launch FSM; start pulse is registered alongside the LAUNCH state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      start_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= launch_s ? ST_LAUNCH : ST_IDLE;
          start_r <= launch_s;
        end
        ST_LAUNCH: begin
          state_r <= ST_RUN;
          start_r <= 1'b0;
        end
        ST_RUN: begin
          state_r <= busy_i ? ST_RUN : ST_IDLE;
          start_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          start_r <= 1'b0;
        end
      endcase
    end
  end

  // Busy-cycle counter: counts every non-IDLE cycle including the exit cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_r <= 32'd0;
    end else if (launch_s) begin
      perf_r <= 32'd0;
    end else if ((state_r != ST_IDLE) && (perf_r != 32'hFFFF_FFFF)) begin
      perf_r <= perf_r + 32'd1;
    end
  end

  // Single-entry response buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'd0;
    end else if (rd_fire_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= rd_data_s;
    end else if (csr_rsp_ready_i) begin
      rsp_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snax_csr_regfile.sv
// Directed bench for snax_csr_regfile: read responses are predicted into a queue
// at issue time and compared when the response handshake occurs.
module tb_snax_csr_regfile;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [31:0]       csr_req_bits_data_i;
  logic [31:0]       csr_req_bits_addr_i;
  logic              csr_req_bits_write_i;
  logic              csr_req_valid_i;
  logic              csr_req_ready_o;
  logic [31:0]       csr_rsp_bits_data_o;
  logic              csr_rsp_valid_o;
  logic              csr_rsp_ready_i;
  logic [7:0][31:0]  csr_o;
  logic [1:0][31:0]  csr_ro_i;
  logic              start_o;
  logic              busy_i;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_start = 0;
  int          waited;
  logic [31:0] exp_q[$];

  snax_csr_regfile #(.NumRwCsr(8), .NumRoCsr(2)) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .csr_req_bits_data_i  (csr_req_bits_data_i),
    .csr_req_bits_addr_i  (csr_req_bits_addr_i),
    .csr_req_bits_write_i (csr_req_bits_write_i),
    .csr_req_valid_i      (csr_req_valid_i),
    .csr_req_ready_o      (csr_req_ready_o),
    .csr_rsp_bits_data_o  (csr_rsp_bits_data_o),
    .csr_rsp_valid_o      (csr_rsp_valid_o),
    .csr_rsp_ready_i      (csr_rsp_ready_i),
    .csr_o                (csr_o),
    .csr_ro_i             (csr_ro_i),
    .start_o              (start_o),
    .busy_i               (busy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int nwait);
    csr_req_valid_i      = 1'b1;
    csr_req_bits_write_i = w;
    csr_req_bits_addr_i  = a;
    csr_req_bits_data_i  = d;
    nwait = 0;
    forever begin
      @(negedge clk_i);
      if (csr_req_ready_o) break;
      nwait++;
      if (nwait > 200) begin
        n_cmp++;
        n_err++;
        $error("FAIL accept_timeout: addr %0d not accepted after %0d cycles", a, nwait);
        break;
      end
    end
    @(posedge clk_i);
    #1;
    csr_req_valid_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    int nw;
    exp_q.push_back(exp);
    send(1'b0, a, 32'd0, nw);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    int nw;
    send(1'b1, a, d, nw);
  endtask

  // Response scoreboard: pop one prediction per consumed response.
  always @(negedge clk_i) begin
    if (rst_ni && csr_rsp_valid_o && csr_rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", csr_rsp_bits_data_o, 32'hXXXX_XXXX);
      end else begin
        check("rsp_data", csr_rsp_bits_data_o, exp_q.pop_front());
      end
    end
    if (start_o) n_start++;
  end

  initial begin
    rst_ni               = 1'b0;
    csr_req_bits_data_i  = 32'd0;
    csr_req_bits_addr_i  = 32'd0;
    csr_req_bits_write_i = 1'b0;
    csr_req_valid_i      = 1'b0;
    csr_rsp_ready_i      = 1'b1;
    csr_ro_i[0]          = 32'h11;
    csr_ro_i[1]          = 32'h22;
    busy_i               = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_rsp_valid", {31'd0, csr_rsp_valid_o}, 32'd0);
    check("rst_rsp_data", csr_rsp_bits_data_o, 32'd0);
    check("rst_start", {31'd0, start_o}, 32'd0);
    check("rst_csr3", csr_o[3], 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Config write and read-back.
    wr(32'd3, 32'hDEAD_BEEF);
    check("csr3_after_wr", csr_o[3], 32'hDEAD_BEEF);
    rd(32'd3, 32'hDEAD_BEEF);
    check("rd_latency_valid", {31'd0, csr_rsp_valid_o}, 32'd1);

    // Back-to-back reads.
    wr(32'd0, 32'h100);
    wr(32'd1, 32'h101);
    wr(32'd2, 32'h102);
    rd(32'd0, 32'h100);
    rd(32'd1, 32'h101);
    rd(32'd2, 32'h102);
    rd(32'd3, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk_i);
    #1;

    // Response stall: buffer holds, further requests blocked.
    csr_rsp_ready_i = 1'b0;
    rd(32'd2, 32'h102);
    csr_req_valid_i      = 1'b1;
    csr_req_bits_write_i = 1'b0;
    csr_req_bits_addr_i  = 32'd0;
    exp_q.push_back(32'h100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("stall_ready", {31'd0, csr_req_ready_o}, 32'd0);
      check("stall_valid", {31'd0, csr_rsp_valid_o}, 32'd1);
      check("stall_data", csr_rsp_bits_data_o, 32'h102);
    end
    @(posedge clk_i);
    #1;
    csr_rsp_ready_i = 1'b1;
    send(1'b0, 32'd0, 32'd0, waited);

    // RO status, unmapped address, dropped RO write, control in IDLE.
    rd(32'd9, 32'h11);
    rd(32'd10, 32'h22);
    rd(32'd200, 32'd0);
    wr(32'd9, 32'hFFFF_FFFF);
    rd(32'd9, 32'h11);
    wr(32'd8, 32'd0);
    check("ctrl_zero_no_start", {31'd0, start_o}, 32'd0);
    rd(32'd8, 32'd0);

    // Launch with busy held for 10 RUN cycles.
    wr(32'd8, 32'd1);
    check("launch_start", {31'd0, start_o}, 32'd1);
    busy_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("run_start_low", {31'd0, start_o}, 32'd0);
    rd(32'd11, 32'd1);
    rd(32'd8, 32'd2);
    csr_req_valid_i      = 1'b1;
    csr_req_bits_write_i = 1'b1;
    csr_req_bits_addr_i  = 32'd0;
    csr_req_bits_data_i  = 32'h0000_AAAA;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      check("run_wr_stall", {31'd0, csr_req_ready_o}, 32'd0);
    end
    @(posedge clk_i);
    #1;
    busy_i = 1'b0;
    send(1'b1, 32'd0, 32'h0000_AAAA, waited);
    check("run_wr_wait", 32'(waited), 32'd1);
    check("csr0_after_run", csr_o[0], 32'h0000_AAAA);
    rd(32'd11, 32'd12);
    rd(32'd8, 32'd0);
    check("start_pulses", 32'(n_start), 32'd1);

    // Reset during RUN with a response pending.
    wr(32'd8, 32'd1);
    busy_i = 1'b1;
    @(posedge clk_i);
    #1;
    csr_rsp_ready_i = 1'b0;
    send(1'b0, 32'd3, 32'd0, waited);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_rsp_valid", {31'd0, csr_rsp_valid_o}, 32'd0);
    check("arst_start", {31'd0, start_o}, 32'd0);
    for (int i = 0; i < 8; i++) check("arst_csr", csr_o[i], 32'd0);
    busy_i = 1'b0;
    csr_rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    rd(32'd8, 32'd0);
    rd(32'd11, 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snax_csr_regfile.md
# snax_csr_regfile

CSR register bank that sits directly downstream of the SNAX interface translator and consumes its simplified CSR request/response ports. It holds accelerator configuration registers, launches the accelerator through a control CSR, and interlocks configuration writes while the accelerator runs. It returns read data through a single-entry registered response buffer, and it exposes read-only status and a busy-cycle performance counter.

## Interface
- NumRwCsr, default 8: number of 32-bit configuration CSRs, must be at least 1.
- NumRoCsr, default 2: number of 32-bit read-only status CSRs supplied by the accelerator, must be at least 1.
- clk_i  in  1  clock; the block uses one clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- csr_req_bits_data_i  in  32  write data.
- csr_req_bits_addr_i  in  32  CSR index, already offset-corrected.
- csr_req_bits_write_i  in  1  1 = write, 0 = read.
- csr_req_valid_i  in  1  request valid.
- csr_req_ready_o  out  1  request accepted when both valid and ready are high.
- csr_rsp_bits_data_o  out  32  read data.
- csr_rsp_valid_o  out  1  response valid.
- csr_rsp_ready_i  in  1  response consumed.
- csr_o  out  NumRwCsr×32  current configuration register values.
- csr_ro_i  in  NumRoCsr×32  accelerator status words.
- start_o  out  1  single-cycle launch pulse.
- busy_i  in  1  accelerator is running.

## Operation
- Address map:
  - 0..NumRwCsr-1: configuration, RW.
  - NumRwCsr: control.
  - NumRwCsr+1..NumRwCsr+NumRoCsr: csr_ro_i[i], RO.
  - NumRwCsr+NumRoCsr+1: PERF, RO.
  - Any higher address: reads return 0, writes are dropped.
- Configuration write: the register takes csr_req_bits_data_i on the accepting edge.
- Control write:
  - In IDLE with data bit0=1, the FSM moves to LAUNCH.
  - Any other data is accepted with no effect.
  - Control reads return {30'b0, state!=IDLE, 1'b0}.
- Writes to RO addresses are accepted and ignored. Writes produce no response; only reads produce one.
- FSM states are IDLE, LAUNCH and RUN:
  - IDLE goes to LAUNCH on an accepted start write.
  - LAUNCH goes to RUN unconditionally after 1 cycle. start_o is 1 only in LAUNCH.
  - RUN goes to IDLE in the first cycle where busy_i=0. busy_i is sampled starting the cycle after LAUNCH.
- Write interlock: in LAUNCH or RUN, csr_req_ready_o=0 for every write at any address. Reads are never interlocked.
- PERF counter:
  - Cleared to 0 on the IDLE-to-LAUNCH transition.
  - Increments by 1 every cycle in LAUNCH or RUN.
  - Saturates at 32'hFFFF_FFFF.
  - Holds its value in IDLE.
- Ready rule: csr_req_ready_o = (!csr_rsp_valid_o || csr_rsp_ready_i) && (!csr_req_bits_write_i || state==IDLE).
  - Writes also wait on a pending response, which keeps ordering with the upstream ID FIFO.

## Timing
- Read latency: a read accepted at edge t drives csr_rsp_valid_o=1 from t+1. Data comes from register state before edge t; a simultaneous write does not exist because only one request is accepted per cycle.
- The response holds data and valid stable until csr_rsp_ready_i=1.
- Back-to-back reads:
  - If the response is consumed in the same cycle a new read is accepted, csr_rsp_valid_o stays 1 and the data updates. Throughput is 1 read per cycle.
  - If the response is consumed with no new read, csr_rsp_valid_o drops at the next edge.
- Write to start: accepted at t gives LAUNCH at t+1 (start_o=1) and RUN at t+2. The earliest return to IDLE is t+3 if busy_i=0 at t+2.
- csr_o changes the edge after write acceptance.
- Reset values: all csr_o 0, csr_rsp_valid_o 0, csr_rsp_bits_data_o 0, start_o 0, state IDLE, PERF 0. A reset mid-operation drops any pending response and aborts LAUNCH/RUN without a pulse.
- There is no combinational path from csr_rsp_ready_i to csr_rsp_valid_o. A combinational path from csr_req_bits_write_i and csr_rsp_ready_i to csr_req_ready_o is allowed.

## Structure
- Package snax_csr_pkg holds:
  - the FSM state enum (IDLE, LAUNCH, RUN);
  - the control-bit index localparam (start = bit0);
  - address-map helper functions derived from NumRwCsr and NumRoCsr.
- A single flat module; no sub-module is needed. Register bank, FSM, PERF counter and response register live inline.

## Test plan
- Write 0xDEADBEEF to address 3, then read address 3 -> csr_o[3]=0xDEADBEEF one edge after acceptance; response data 0xDEADBEEF one cycle after the read is accepted.
- 4 back-to-back reads with csr_rsp_ready_i=1 -> 4 consecutive response cycles in order. Hold csr_rsp_ready_i=0 for 3 cycles -> csr_req_ready_o=0 and the response is stable.
- Write 1 to address NumRwCsr=8 with busy_i high for 10 cycles after LAUNCH -> start_o exactly 1 cycle; a write to address 0 during RUN stalls until IDLE; reads of address 11 (PERF) during RUN are nonzero. Final PERF = 12: 1 LAUNCH cycle, 10 busy RUN cycles, and 1 exit cycle.
- Read addresses 9/10 with csr_ro_i={0x11,0x22} -> 0x11, 0x22. Read address 200 -> 0. Write to address 9 -> accepted, no effect.
- Assert rst_ni=0 during RUN with a response pending -> csr_rsp_valid_o=0, state IDLE, csr_o all 0 immediately. After release, a read of address 8 returns 0.
